output_argmax: RTL and testbench
================================

Name: output_argmax

Overview:
- Classifier stage that sits directly downstream of the network's output layer.
- Snapshots the signed output vector when the upstream `outputs_ready` pulses, then scans it sequentially, one element per cycle.
- Reports the index and value of the largest element, followed by a one-cycle done pulse.
- Used as the final decision stage for a board-level classification result.

Parameters:
- DATA_WIDTH, 32, width of each signed element (same fixed-point format as the network).
- NUM_INPUTS, 2, number of elements in the vector; must be >= 1.
- THRESHOLD, 0, signed confidence threshold; used only with ARGMAX_THRESHOLD_EN.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inputs_ready  input  1  one-cycle pulse meaning inputs are valid; driven by the upstream layer's outputs_ready.
- inputs  input  NUM_INPUTS x DATA_WIDTH signed  vector to classify; valid only in the cycle inputs_ready is high.
- class_index  output  IW = max(1,$clog2(NUM_INPUTS))  index of the maximum element.
- max_value  output  DATA_WIDTH signed  value of the maximum element.
- outputs_ready  output  1  one-cycle pulse; class_index/max_value are valid.
- busy  output  1  high while a scan is in progress.
- overrun  output  1  sticky flag; set when an inputs_ready pulse is dropped.
- above_threshold  output  1  max_value >= THRESHOLD (see Optional Feature).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high. All state is registered.
- Reset values: state=IDLE; class_index=0, max_value=0, outputs_ready=0, busy=0, overrun=0, above_threshold=0; snapshot, scan counter and best registers all 0.
- State machine: IDLE, SCAN, DONE.
- IDLE, inputs_ready=1:
  - Capture all NUM_INPUTS elements into the snapshot.
  - best_value<=inputs[0], best_index<=0, idx<=1.
  - Next state is SCAN if NUM_INPUTS>1, otherwise DONE.
- SCAN, each cycle:
  - If snapshot[idx] > best_value (strict, signed), update best_value/best_index.
  - If idx==NUM_INPUTS-1, go to DONE and load class_index/max_value from the final best, including this cycle's comparison. Otherwise idx<=idx+1.
- DONE: outputs_ready=1 for exactly this cycle.
  - If inputs_ready=1 in this cycle, accept it as in IDLE (back-to-back operation, no bubble).
  - Otherwise go to IDLE.
- Latency: inputs_ready sampled high in cycle T gives outputs_ready high in cycle T+NUM_INPUTS. Throughput is one vector per NUM_INPUTS cycles.
- busy=1 in SCAN; busy=0 in IDLE and DONE.
- Dropped inputs: inputs_ready=1 while in SCAN is ignored (the snapshot is not disturbed) and overrun<=1. overrun clears only on reset.
- Ties: the lowest index wins (strict > comparison).
- Signed handling: comparison is full-width two's complement. The most negative value is legal; an all-negative vector returns its largest (least negative) element.
- class_index and max_value hold their last result until the next DONE; they do not change during SCAN.
- Reset mid-scan: return immediately to IDLE with all outputs at reset values; the partial result is discarded, no outputs_ready.
- idx width is IW; it never exceeds NUM_INPUTS-1 and never wraps.

Optional Feature:
- ARGMAX_THRESHOLD_EN defined:
  - above_threshold is registered in the DONE transition as (final max_value >= THRESHOLD, signed).
  - It holds with class_index until the next result; reset value 0.
- ARGMAX_THRESHOLD_EN undefined:
  - above_threshold is tied to 1 after the first result and is 0 from reset until then.
  - THRESHOLD is unused and no compare logic is built.

Test Plan:
- Basic argmax (NUM_INPUTS=4): inputs {5,-3,17,2}, inputs_ready pulse at cycle T -> outputs_ready only at T+4, class_index=2, max_value=17, busy high for cycles T+1..T+3.
- Negatives and tie (NUM_INPUTS=4): {-8,-2,-2,-0x7FFFFFFF} -> class_index=1, max_value=-2. Then {0x80000000 repeated 4 times} -> class_index=0.
- Back-to-back (NUM_INPUTS=4): second pulse in the DONE cycle carrying {1,9,0,0} -> second outputs_ready 4 cycles after the first, class_index=1, overrun stays 0.
- Overrun and reset (NUM_INPUTS=4): pulse during SCAN -> ignored, result unchanged, overrun=1. Then assert reset mid-scan -> all outputs 0 immediately, no outputs_ready pulse, overrun=0.
- Edge size and default (NUM_INPUTS=1, then the default 2): {42} -> outputs_ready at T+1, class_index=0, max_value=42. Default {3,7} -> class_index=1 at T+2.
- Threshold (ARGMAX_THRESHOLD_EN, THRESHOLD=10):
  - {4,9} -> above_threshold=0.
  - {4,10} -> above_threshold=1.
  - Without the macro, the same vectors -> above_threshold=1.

Source files
------------

// File: rtl/output_argmax.sv
// Argmax classifier: snapshots the output vector, scans one element per cycle, pulses the winner.
// Optional ARGMAX_THRESHOLD_EN registers above_threshold as (max_value >= THRESHOLD).
module output_argmax #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 2,
   parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = '0,
   localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         inputs_ready,
   input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
   output logic [IW-1:0]                class_index,
   output logic signed [DATA_WIDTH-1:0] max_value,
   output logic                         outputs_ready,
   output logic                         busy,
   output logic                         overrun,
   output logic                         above_threshold
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                  state;
   logic signed [DATA_WIDTH-1:0] snapshot [NUM_INPUTS];
   logic [IW-1:0]               idx;
   logic signed [DATA_WIDTH-1:0] best_value;
   logic [IW-1:0]               best_index;

   logic signed [DATA_WIDTH-1:0] scan_value;
   logic [IW-1:0]               scan_index;
   logic                        scan_last;
   logic signed [DATA_WIDTH-1:0] result_value;
   logic                        result_above;

   // Strict '>' keeps the earlier (lower) index on ties.
   always_comb begin
      scan_value = best_value;
      scan_index = best_index;
      if (snapshot[idx] > best_value) begin
         scan_value = snapshot[idx];
         scan_index = idx;
      end
      scan_last    = (idx == IW'(NUM_INPUTS - 1));
      result_value = (state == S_SCAN) ? scan_value : inputs[0];
   end

`ifdef ARGMAX_THRESHOLD_EN
   assign result_above = (result_value >= THRESHOLD);
`else
   logic unused_threshold;
   assign unused_threshold = ^THRESHOLD;
   assign result_above     = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         idx             <= '0;
         best_value      <= '0;
         best_index      <= '0;
         class_index     <= '0;
         max_value       <= '0;
         outputs_ready   <= 1'b0;
         busy            <= 1'b0;
         overrun         <= 1'b0;
         above_threshold <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) snapshot[i] <= '0;
      end else begin
         outputs_ready <= 1'b0;
         case (state)
            S_SCAN: begin
               // A new vector arriving mid-scan is dropped; the snapshot stays intact.
               if (inputs_ready) overrun <= 1'b1;
               best_value <= scan_value;
               best_index <= scan_index;
               if (scan_last) begin
                  state           <= S_DONE;
                  busy            <= 1'b0;
                  outputs_ready   <= 1'b1;
                  class_index     <= scan_index;
                  max_value       <= scan_value;
                  above_threshold <= result_above;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: begin
               // IDLE and DONE both accept a new vector, giving back-to-back operation.
               if (inputs_ready) begin
                  snapshot   <= inputs;
                  best_value <= inputs[0];
                  best_index <= '0;
                  idx        <= (NUM_INPUTS > 1) ? IW'(1) : '0;
                  if (NUM_INPUTS > 1) begin
                     state <= S_SCAN;
                     busy  <= 1'b1;
                  end else begin
                     state           <= S_DONE;
                     outputs_ready   <= 1'b1;
                     class_index     <= '0;
                     max_value       <= result_value;
                     above_threshold <= result_above;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: 4-, 1- and 2-element instances driven from one sequence.
module tb_output_argmax;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 4-element instance
   logic               rdy4;
   logic signed [31:0] in4 [4];
   logic [1:0]         idx4;
   logic signed [31:0] max4;
   logic               or4, busy4, ovr4, abv4;

   // 1-element instance
   logic               rdy1;
   logic signed [31:0] in1 [1];
   logic [0:0]         idx1;
   logic signed [31:0] max1;
   logic               or1, busy1, ovr1, abv1;

   // 2-element instance, threshold 10
   logic               rdy2;
   logic signed [31:0] in2 [2];
   logic [0:0]         idx2;
   logic signed [31:0] max2;
   logic               or2, busy2, ovr2, abv2;

   output_argmax #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut4 (
      .clock(clk), .reset(rst), .inputs_ready(rdy4), .inputs(in4),
      .class_index(idx4), .max_value(max4), .outputs_ready(or4),
      .busy(busy4), .overrun(ovr4), .above_threshold(abv4));

   output_argmax #(.DATA_WIDTH(32), .NUM_INPUTS(1)) dut1 (
      .clock(clk), .reset(rst), .inputs_ready(rdy1), .inputs(in1),
      .class_index(idx1), .max_value(max1), .outputs_ready(or1),
      .busy(busy1), .overrun(ovr1), .above_threshold(abv1));

   output_argmax #(.DATA_WIDTH(32), .NUM_INPUTS(2), .THRESHOLD(32'sd10)) dut2 (
      .clock(clk), .reset(rst), .inputs_ready(rdy2), .inputs(in2),
      .class_index(idx2), .max_value(max2), .outputs_ready(or2),
      .busy(busy2), .overrun(ovr2), .above_threshold(abv2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

`ifdef ARGMAX_THRESHOLD_EN
   localparam logic THR_ON = 1'b1;
`else
   localparam logic THR_ON = 1'b0;
`endif

   initial begin
      rst  = 1'b1;
      rdy4 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
      in4  = '{32'sd0, 32'sd0, 32'sd0, 32'sd0};
      in1  = '{32'sd0};
      in2  = '{32'sd0, 32'sd0};
      neg(3);
      chk("rst_idx4",  32'(idx4), 32'd0);
      chk("rst_max4",  max4,      32'd0);
      chk("rst_or4",   32'(or4),  32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_ovr4",  32'(ovr4), 32'd0);
      chk("rst_abv4",  32'(abv4), 32'd0);
      chk("rst_abv2",  32'(abv2), 32'd0);
      rst = 1'b0;
      neg(1);

      // Basic argmax {5,-3,17,2}
      in4 = '{32'sd5, -32'sd3, 32'sd17, 32'sd2}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      chk("b_busy1", 32'(busy4), 32'd1); chk("b_or1", 32'(or4), 32'd0);
      neg(1);
      chk("b_busy2", 32'(busy4), 32'd1); chk("b_or2", 32'(or4), 32'd0);
      chk("b_hold_idx", 32'(idx4), 32'd0);
      neg(1);
      chk("b_busy3", 32'(busy4), 32'd1); chk("b_or3", 32'(or4), 32'd0);
      neg(1);
      chk("b_or4", 32'(or4), 32'd1); chk("b_busy4", 32'(busy4), 32'd0);
      chk("b_idx", 32'(idx4), 32'd2); chk("b_max", max4, 32'd17);
      chk("b_abv", 32'(abv4), 32'd1);
      neg(1);
      chk("b_or5", 32'(or4), 32'd0); chk("b_idx_hold", 32'(idx4), 32'd2);

      // Negatives with a tie at -2
      in4 = '{-32'sd8, -32'sd2, -32'sd2, -32'sh7FFFFFFF}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(3);
      chk("n_or", 32'(or4), 32'd1); chk("n_idx", 32'(idx4), 32'd1);
      chk("n_max", max4, 32'hFFFF_FFFE);
      chk("n_abv", 32'(abv4), THR_ON ? 32'd0 : 32'd1);
      neg(1);
      // All most-negative: lowest index wins
      in4 = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(3);
      chk("m_or", 32'(or4), 32'd1); chk("m_idx", 32'(idx4), 32'd0);
      chk("m_max", max4, 32'h8000_0000);
      neg(1);

      // Back-to-back: second pulse in the DONE cycle
      in4 = '{32'sd5, -32'sd3, 32'sd17, 32'sd2}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(3);
      chk("bb_or1", 32'(or4), 32'd1); chk("bb_idx1", 32'(idx4), 32'd2);
      in4 = '{32'sd1, 32'sd9, 32'sd0, 32'sd0}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      chk("bb_busy", 32'(busy4), 32'd1); chk("bb_or_gap", 32'(or4), 32'd0);
      neg(3);
      chk("bb_or2", 32'(or4), 32'd1); chk("bb_idx2", 32'(idx4), 32'd1);
      chk("bb_max2", max4, 32'd9); chk("bb_ovr", 32'(ovr4), 32'd0);
      neg(1);

      // Overrun: pulse mid-scan is ignored
      in4 = '{32'sd5, -32'sd3, 32'sd17, 32'sd2}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(1);
      in4 = '{32'sd100, 32'sd100, 32'sd100, 32'sd100}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(1);
      chk("o_or", 32'(or4), 32'd1); chk("o_idx", 32'(idx4), 32'd2);
      chk("o_max", max4, 32'd17); chk("o_ovr", 32'(ovr4), 32'd1);
      neg(1);

      // Reset mid-scan
      in4 = '{32'sd1, 32'sd9, 32'sd0, 32'sd0}; rdy4 = 1'b1;
      neg(1); rdy4 = 1'b0;
      neg(1);
      rst = 1'b1;
      #1;
      chk("r_idx", 32'(idx4), 32'd0); chk("r_max", max4, 32'd0);
      chk("r_busy", 32'(busy4), 32'd0); chk("r_ovr", 32'(ovr4), 32'd0);
      chk("r_or", 32'(or4), 32'd0); chk("r_abv", 32'(abv4), 32'd0);
      neg(1); rst = 1'b0;
      neg(1); chk("r_or_a", 32'(or4), 32'd0);
      neg(1); chk("r_or_b", 32'(or4), 32'd0);
      neg(1); chk("r_or_c", 32'(or4), 32'd0); chk("r_busy_c", 32'(busy4), 32'd0);

      // Single element
      in1 = '{32'sd42}; rdy1 = 1'b1;
      neg(1); rdy1 = 1'b0;
      chk("s_or", 32'(or1), 32'd1); chk("s_idx", 32'(idx1), 32'd0);
      chk("s_max", max1, 32'd42); chk("s_busy", 32'(busy1), 32'd0);
      neg(1);
      chk("s_or2", 32'(or1), 32'd0);

      // Two elements, threshold 10
      chk("t_abv_init", 32'(abv2), 32'd0);
      in2 = '{32'sd3, 32'sd7}; rdy2 = 1'b1;
      neg(1); rdy2 = 1'b0;
      chk("d_or1", 32'(or2), 32'd0); chk("d_busy1", 32'(busy2), 32'd1);
      neg(1);
      chk("d_or2", 32'(or2), 32'd1); chk("d_idx", 32'(idx2), 32'd1);
      chk("d_max", max2, 32'd7);
      chk("d_abv", 32'(abv2), THR_ON ? 32'd0 : 32'd1);
      neg(1);
      in2 = '{32'sd4, 32'sd9}; rdy2 = 1'b1;
      neg(1); rdy2 = 1'b0;
      neg(1);
      chk("t9_or", 32'(or2), 32'd1); chk("t9_max", max2, 32'd9);
      chk("t9_abv", 32'(abv2), THR_ON ? 32'd0 : 32'd1);
      neg(1);
      in2 = '{32'sd4, 32'sd10}; rdy2 = 1'b1;
      neg(1); rdy2 = 1'b0;
      neg(1);
      chk("t10_or", 32'(or2), 32'd1); chk("t10_max", max2, 32'd10);
      chk("t10_idx", 32'(idx2), 32'd1); chk("t10_abv", 32'(abv2), 32'd1);
      neg(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
